// File: rtl/led_sequencer.sv
// LED game round controller: plays a stored pattern of LED indices, then checks the player's presses.
// Optional build macro LED_SEQ_ECHO_EN lights each accepted correct press for GAP_CYCLES cycles.
module led_sequencer #(
    parameter int NUM_LEDS       = 4,
    parameter int MAX_LEN        = 16,
    parameter int ON_CYCLES      = 5000,
    parameter int GAP_CYCLES     = 1000,
    parameter int TIMEOUT_CYCLES = 50000,
    localparam int IDX_W         = $clog2(NUM_LEDS),
    localparam int LEN_W         = $clog2(MAX_LEN + 1),
    localparam int AW            = $clog2(MAX_LEN)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                pattern_wr,
    input  logic [AW-1:0]       pattern_addr,
    input  logic [IDX_W-1:0]    pattern_data,
    input  logic [LEN_W-1:0]    round_len,
    input  logic [NUM_LEDS-1:0] btn,
    output logic [NUM_LEDS-1:0] led,
    output logic                busy,
    output logic [AW-1:0]       step,
    output logic                round_ok,
    output logic                round_fail
);

    localparam int CNT_MAX = (ON_CYCLES > GAP_CYCLES)
                           ? ((ON_CYCLES > TIMEOUT_CYCLES) ? ON_CYCLES : TIMEOUT_CYCLES)
                           : ((GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES);
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHOW_ON,
        S_SHOW_GAP,
        S_WAIT_INPUT,
        S_PASS,
        S_FAIL
    } state_t;

    state_t               state, state_d;
    logic [CNT_W-1:0]     cnt, cnt_d;
    logic [AW-1:0]        step_d;
    logic [AW-1:0]        last, last_d;
    logic [NUM_LEDS-1:0]  led_d;
    logic                 busy_d, round_ok_d, round_fail_d;
    logic [IDX_W-1:0]     mem [MAX_LEN];
    logic                 mem_we;
    logic [LEN_W-1:0]     eff_len;
    logic [IDX_W-1:0]     first_idx;
    logic [IDX_W-1:0]     btn_idx;
    logic                 btn_onehot;
    logic [AW-1:0]        step_inc;
`ifdef LED_SEQ_ECHO_EN
    logic [CNT_W-1:0]     echo_cnt, echo_cnt_d;
`endif

    function automatic logic [NUM_LEDS-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_LEDS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Memory is writable only between rounds; a write coincident with start is
    // forwarded so the first lit LED already reflects it.
    assign mem_we    = (state == S_IDLE) && pattern_wr;
    assign first_idx = (pattern_wr && (pattern_addr == '0)) ? pattern_data : mem[0];
    assign step_inc  = step + AW'(1);

    always_comb begin
        eff_len = round_len;
        if (round_len == '0) begin
            eff_len = LEN_W'(1);
        end else if (round_len > LEN_W'(MAX_LEN)) begin
            eff_len = LEN_W'(MAX_LEN);
        end
    end

    always_comb begin
        btn_idx = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (btn[i]) begin
                btn_idx = IDX_W'(i);
            end
        end
    end

    assign btn_onehot = (btn != '0) && ((btn & (btn - NUM_LEDS'(1))) == '0);

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        step_d  = step;
        last_d  = last;
        led_d   = led;
`ifdef LED_SEQ_ECHO_EN
        echo_cnt_d = '0;
`endif
        case (state)
            S_IDLE: begin
                led_d  = '0;
                step_d = '0;
                cnt_d  = '0;
                if (start) begin
                    last_d  = AW'(eff_len - LEN_W'(1));
                    led_d   = onehot(first_idx);
                    state_d = S_SHOW_ON;
                end
            end
            S_SHOW_ON: begin
                if (cnt == ON_LAST) begin
                    cnt_d   = '0;
                    led_d   = '0;
                    state_d = S_SHOW_GAP;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_SHOW_GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_d = '0;
                    if (step == last) begin
                        step_d  = '0;
                        state_d = S_WAIT_INPUT;
                    end else begin
                        step_d  = step_inc;
                        led_d   = onehot(mem[step_inc]);
                        state_d = S_SHOW_ON;
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_WAIT_INPUT: begin
`ifdef LED_SEQ_ECHO_EN
                // Echo runs down independently of the timeout counter.
                if (led != '0) begin
                    if (echo_cnt == '0) begin
                        led_d = '0;
                    end else begin
                        echo_cnt_d = echo_cnt - CNT_W'(1);
                    end
                end
`else
                led_d = '0;
`endif
                if (btn == '0) begin
                    if (cnt == TO_LAST) begin
                        led_d   = '0;
                        state_d = S_FAIL;
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end else if (!btn_onehot || (btn_idx != mem[step])) begin
                    led_d   = '0;
                    state_d = S_FAIL;
                end else begin
                    cnt_d = '0;
                    if (step == last) begin
                        led_d   = '0;
                        state_d = S_PASS;
                    end else begin
                        step_d = step_inc;
`ifdef LED_SEQ_ECHO_EN
                        led_d      = onehot(btn_idx);
                        echo_cnt_d = GAP_LAST;
`endif
                    end
                end
            end
            S_PASS, S_FAIL: begin
                led_d   = '0;
                cnt_d   = '0;
                step_d  = '0;
                state_d = S_IDLE;
            end
            default: begin
                led_d   = '0;
                cnt_d   = '0;
                step_d  = '0;
                state_d = S_IDLE;
            end
        endcase

        busy_d       = (state_d != S_IDLE);
        round_ok_d   = (state_d == S_PASS);
        round_fail_d = (state_d == S_FAIL);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            step       <= '0;
            last       <= '0;
            led        <= '0;
            busy       <= 1'b0;
            round_ok   <= 1'b0;
            round_fail <= 1'b0;
`ifdef LED_SEQ_ECHO_EN
            echo_cnt   <= '0;
`endif
            for (int i = 0; i < MAX_LEN; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            step       <= step_d;
            last       <= last_d;
            led        <= led_d;
            busy       <= busy_d;
            round_ok   <= round_ok_d;
            round_fail <= round_fail_d;
`ifdef LED_SEQ_ECHO_EN
            echo_cnt   <= echo_cnt_d;
`endif
            if (mem_we) begin
                mem[pattern_addr] <= pattern_data;
            end
        end
    end

endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer (default build, echo disabled) against a pattern-level reference model.
module tb_led_sequencer;

    localparam int ON  = 4;
    localparam int GAP = 2;
    localparam int TO  = 10;
    localparam int PER = ON + GAP;

    localparam int M_PASS    = 0;
    localparam int M_WRONG   = 1;
    localparam int M_TIMEOUT = 2;
    localparam int M_MULTI   = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       pattern_wr;
    logic [3:0] pattern_addr;
    logic [1:0] pattern_data;
    logic [4:0] round_len;
    logic [3:0] btn;
    logic [3:0] led;
    logic       busy;
    logic [3:0] step;
    logic       round_ok;
    logic       round_fail;

    int         n_vec = 0;
    int         n_err = 0;
    logic [1:0] model_mem [16];
    logic [3:0] exp_q [$];

    led_sequencer #(
        .NUM_LEDS(4), .MAX_LEN(16), .ON_CYCLES(ON), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pattern_wr(pattern_wr),
        .pattern_addr(pattern_addr), .pattern_data(pattern_data), .round_len(round_len),
        .btn(btn), .led(led), .busy(busy), .step(step),
        .round_ok(round_ok), .round_fail(round_fail)
    );

    // Clock and reset: inputs change and outputs are sampled at the falling edge.
    always #5 clk = ~clk;

    function automatic logic [3:0] oh(input int idx);
        logic [3:0] v;
        v = 4'b0001 << idx;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic wait_chk(input int n_acc);
        chk("wait_led", 32'(led), 32'h0);
        chk("wait_busy", 32'(busy), 32'h1);
        chk("wait_step", 32'(step), 32'(n_acc));
        chk("wait_ok", 32'(round_ok), 32'h0);
        chk("wait_fail", 32'(round_fail), 32'h0);
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_led"}, 32'(led), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_step"}, 32'(step), 32'h0);
        chk({tag, "_ok"}, 32'(round_ok), 32'h0);
        chk({tag, "_fail"}, 32'(round_fail), 32'h0);
    endtask

    task automatic write_pat(input int addr, input int data);
        pattern_wr   = 1'b1;
        pattern_addr = 4'(addr);
        pattern_data = 2'(data);
        model_mem[addr] = 2'(data);
        @(negedge clk);
        pattern_wr = 1'b0;
    endtask

    // One full round: playback with bus noise, then the chosen player response.
    task automatic play_round(input int rlen, input int mode, input int pos, input int woff,
                              input logic [3:0] bad, input bit wr_start);
        int eff;
        int npress;
        int nacc;
        int gap;
        int wi;
        logic [3:0] exp_led;
        eff = (rlen == 0) ? 1 : ((rlen > 16) ? 16 : rlen);
        if (pos > eff - 1) pos = eff - 1;

        round_len = 5'(rlen);
        start     = 1'b1;
        btn       = 4'h0;
        if (wr_start) begin
            pattern_wr   = 1'b1;
            pattern_addr = 4'h0;
            pattern_data = 2'($urandom_range(0, 3));
            model_mem[0] = pattern_data;
        end
        @(negedge clk);
        start      = 1'b0;
        pattern_wr = 1'b0;

        exp_q.delete();
        for (int e = 0; e < eff; e++) begin
            for (int c = 0; c < ON; c++) exp_q.push_back(oh(int'(model_mem[e])));
            for (int c = 0; c < GAP; c++) exp_q.push_back(4'h0);
        end

        for (int k = 0; k < eff * PER; k++) begin
            exp_led = exp_q.pop_front();
            chk("play_led", 32'(led), 32'(exp_led));
            chk("play_busy", 32'(busy), 32'h1);
            chk("play_step", 32'(step), 32'(k / PER));
            btn          = 4'($urandom);
            start        = 1'($urandom_range(0, 1));
            round_len    = 5'($urandom);
            pattern_wr   = 1'($urandom_range(0, 1));
            pattern_addr = 4'($urandom);
            pattern_data = 2'($urandom);
            @(negedge clk);
        end
        btn        = 4'h0;
        start      = 1'b0;
        pattern_wr = 1'b0;

        nacc   = 0;
        npress = (mode == M_PASS) ? eff : pos;
        for (int p = 0; p < npress; p++) begin
            gap = $urandom_range(0, TO - 1);
            for (int g = 0; g < gap; g++) begin
                wait_chk(nacc);
                @(negedge clk);
            end
            wait_chk(nacc);
            btn = oh(int'(model_mem[nacc]));
            @(negedge clk);
            btn  = 4'h0;
            nacc++;
        end

        if (mode == M_PASS) begin
            chk("pass_ok", 32'(round_ok), 32'h1);
            chk("pass_fail", 32'(round_fail), 32'h0);
            chk("pass_busy", 32'(busy), 32'h1);
            chk("pass_step", 32'(step), 32'(eff - 1));
            chk("pass_led", 32'(led), 32'h0);
        end else begin
            wait_chk(nacc);
            if (mode == M_WRONG) begin
                wi  = (int'(model_mem[nacc]) + woff) % 4;
                btn = oh(wi);
                @(negedge clk);
            end else if (mode == M_MULTI) begin
                btn = bad;
                @(negedge clk);
            end else begin
                @(negedge clk);
                for (int g = 1; g < TO; g++) begin
                    wait_chk(nacc);
                    @(negedge clk);
                end
            end
            btn = 4'h0;
            chk("fail_fail", 32'(round_fail), 32'h1);
            chk("fail_ok", 32'(round_ok), 32'h0);
            chk("fail_busy", 32'(busy), 32'h1);
            chk("fail_step", 32'(step), 32'(nacc));
            chk("fail_led", 32'(led), 32'h0);
        end
        btn = 4'($urandom);
        @(negedge clk);
        btn = 4'h0;
        idle_chk("end");
    endtask

    initial begin
        logic [3:0] bad;
        int mode;
        rst_n        = 1'b0;
        start        = 1'b0;
        pattern_wr   = 1'b0;
        pattern_addr = 4'h0;
        pattern_data = 2'h0;
        round_len    = 5'h0;
        btn          = 4'h0;
        for (int i = 0; i < 16; i++) model_mem[i] = 2'h0;
        repeat (3) @(negedge clk);
        idle_chk("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed: playback {2,0,3} followed by a correct response.
        write_pat(0, 2);
        write_pat(1, 0);
        write_pat(2, 3);
        play_round(3, M_PASS, 0, 1, 4'h0, 1'b0);

        // Wrong button: pattern {1}, press 0001.
        write_pat(0, 1);
        play_round(1, M_WRONG, 0, 3, 4'h0, 1'b0);

        // Timeout with no press, timeout after one press, and a multi-button press.
        write_pat(0, 2);
        play_round(3, M_TIMEOUT, 0, 1, 4'h0, 1'b0);
        play_round(3, M_TIMEOUT, 1, 1, 4'h0, 1'b0);
        play_round(3, M_MULTI, 0, 1, 4'b0011, 1'b0);

        // Length clamping at both ends.
        play_round(0, M_PASS, 0, 1, 4'h0, 1'b0);
        for (int i = 0; i < 16; i++) write_pat(i, $urandom_range(0, 3));
        play_round(20, M_PASS, 0, 1, 4'h0, 1'b0);

        // Write and start in the same cycle.
        play_round(2, M_PASS, 0, 1, 4'h0, 1'b1);

        // Reset in the middle of SHOW_ON clears outputs and memory.
        round_len = 5'd3;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        idle_chk("midrst");
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) model_mem[i] = 2'h0;
        @(negedge clk);
        play_round(1, M_PASS, 0, 1, 4'h0, 1'b0);

        // Randomized rounds.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 16; i++) write_pat(i, $urandom_range(0, 3));
            mode = $urandom_range(0, 3);
            do bad = 4'($urandom_range(3, 15)); while ($countones(bad) < 2);
            play_round($urandom_range(0, 20), mode, $urandom_range(0, 15),
                       $urandom_range(1, 3), bad, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/led_sequencer.md
# led_sequencer

Round controller for the LED game. It stores a pattern of LED indices and plays the first `round_len` entries, lighting each LED for a fixed on-time with a dark gap between entries. It then checks the player's button presses against the pattern and reports pass or fail. It sits between the game top level (pattern/round control) and the board LEDs and debounced buttons, and sequences LED display timing.

## Interface

- `NUM_LEDS`, 4: number of LEDs/buttons; `IDX_W = clog2(NUM_LEDS)`
- `MAX_LEN`, 16: pattern memory depth; `LEN_W = clog2(MAX_LEN+1)`, `AW = clog2(MAX_LEN)`
- `ON_CYCLES`, 5000: cycles each pattern LED is lit
- `GAP_CYCLES`, 1000: dark cycles after each lit LED
- `TIMEOUT_CYCLES`, 50000: max cycles between player presses

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `start`  in  1  begin a round; honoured only when idle
- `pattern_wr`  in  1  write strobe for pattern memory
- `pattern_addr`  in  AW  write address
- `pattern_data`  in  IDX_W  LED index to store
- `round_len`  in  LEN_W  entries to play/check
- `btn`  in  NUM_LEDS  debounced press pulses, one cycle per press
- `led`  out  NUM_LEDS  LED drive, one-hot or zero
- `busy`  out  1  high whenever state is not IDLE
- `step`  out  AW  current pattern index
- `round_ok`  out  1  one-cycle pass pulse
- `round_fail`  out  1  one-cycle fail pulse

## Operation

- States: IDLE, SHOW_ON, SHOW_GAP, WAIT_INPUT, PASS, FAIL.
- Reset (`rst_n`=0 at a clock edge): state IDLE; `led`, `step`, `busy`, `round_ok`, `round_fail`, and all counters are 0; all pattern entries are cleared to 0. Reset overrides any state mid-round.
- IDLE: `pattern_wr` writes `pattern_data` to `pattern_addr`. `start` latches the effective length: 0 becomes 1, and anything above `MAX_LEN` becomes `MAX_LEN`. It sets `step`=0 and enters SHOW_ON.
- While busy, `pattern_wr` and `start` are ignored.
- SHOW_ON: `led` = onehot(pattern[step]) for exactly `ON_CYCLES` cycles, then SHOW_GAP.
- SHOW_GAP: `led`=0 for exactly `GAP_CYCLES` cycles.
  - If `step` equals length−1: `step`←0 and enter WAIT_INPUT.
  - Otherwise: `step`+1 and enter SHOW_ON.
- WAIT_INPUT: the timeout counter clears on entry and on every accepted press. `btn` is evaluated each cycle:
  - `btn`=0: counter +1. Reaching `TIMEOUT_CYCLES` enters FAIL.
  - `btn` not one-hot enters FAIL.
  - One-hot and the index equals pattern[step]: at the last step enter PASS; otherwise `step`+1.
  - One-hot with a mismatching index enters FAIL.
- PASS / FAIL: one cycle each. `round_ok` or `round_fail` is high during that cycle, then the block returns to IDLE. `step` holds its value through PASS/FAIL and clears to 0 on re-entering IDLE.
- Counters are sized `clog2(max(ON,GAP,TIMEOUT)+1)` bits and never wrap within a phase.

## Timing

- All outputs are registered and change only on rising `clk`.
- `start` sampled at edge N: `busy`=1 and `led` lit from edge N+1.
- Full playback lasts length×(`ON_CYCLES`+`GAP_CYCLES`) cycles. WAIT_INPUT begins on the following edge.
- The final correct press at edge M: `round_ok`=1 for the cycle after M, and `busy`=0 from edge M+2.
- Presses arriving during SHOW_ON, SHOW_GAP, PASS, FAIL, or IDLE are ignored.
- `start` and `pattern_wr` arriving together in IDLE: the write completes, and the round uses the updated memory.

## Configuration

- `LED_SEQ_ECHO_EN` defined: in WAIT_INPUT, each accepted correct press lights onehot(index) for `GAP_CYCLES` cycles.
  - A new press restarts the echo with the new index.
  - The echo is cleared on leaving WAIT_INPUT.
  - The echo has no effect on acceptance or timeout.
- Not defined: `led`=0 throughout WAIT_INPUT, PASS, and FAIL.

## Test plan

Bench parameters: `NUM_LEDS`=4, `MAX_LEN`=16, `ON_CYCLES`=4, `GAP_CYCLES`=2, `TIMEOUT_CYCLES`=10.

- **Playback:** write pattern {2,0,3}, `round_len`=3, pulse `start` → `led` shows 0100×4, 0000×2, 0001×4, 0000×2, 1000×4, 0000×2. WAIT_INPUT is entered with `step`=0.
- **Pass:** after the playback above, press btn 0100, 0001, 1000 on separate cycles → `round_ok` for one cycle after the third press; `busy`=0 two edges after that press.
- **Wrong button:** pattern {1}, `round_len`=1, press 0001 → `round_fail` for one cycle; `round_ok` never asserts.
- **Timeout / multi-press:**
  - In WAIT_INPUT, no press for 10 cycles → `round_fail`.
  - Separate run: press 0011 → immediate `round_fail`.
- **Boundaries:**
  - `round_len`=0 plays exactly one entry.
  - `round_len`=20 plays 16 entries.
  - `start` or `pattern_wr` while busy changes nothing.
- **Reset mid-round:** drive `rst_n`=0 during SHOW_ON → next edge `led`=0, `busy`=0, `step`=0; a subsequent round plays LED 0 (memory cleared).
